// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port byte memory (1-cycle read latency) between the CPU and
// the VIDAC engine. VIDAC accesses are relocated to VIDAC_BASE. Grants are registered owner
// decodes. Each master has its own read pipeline with held read data.
// Optional feature: define ARB_STATS_EN to build the saturating CPU stall counter on
// stat_cpu_stall; otherwise that port is tied to zero.

module mem_arbiter #(
  parameter logic [19:0] VIDAC_BASE  = 20'hA0000,
  parameter int unsigned VIDAC_BURST = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_in,
  input  logic        vidac_req,
  input  logic [17:0] vidac_a,
  input  logic [7:0]  vidac_o,
  input  logic        vidac_w,
  output logic        vidac_gnt,
  output logic        vidac_rvalid,
  output logic [7:0]  vidac_i,
  output logic [19:0] mem_a,
  output logic [7:0]  mem_d,
  output logic        mem_we,
  input  logic [7:0]  mem_q,
  output logic [15:0] stat_cpu_stall
);

  localparam int unsigned BurstW = $clog2(VIDAC_BURST + 1);
  localparam logic [BurstW-1:0] BurstMax = BurstW'(VIDAC_BURST);

  localparam logic [1:0] OwnNone  = 2'd0;
  localparam logic [1:0] OwnCpu   = 2'd1;
  localparam logic [1:0] OwnVidac = 2'd2;

  logic [1:0]        owner_q, owner_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              vidac_rvalid_q, vidac_rvalid_d;
  logic [7:0]        cpu_hold_q, cpu_hold_d;
  logic [7:0]        vidac_hold_q, vidac_hold_d;
  logic              cpu_act, vidac_act;
  logic [19:0]       vidac_phys;

  // Next owner: VIDAC wins unless the CPU is waiting and VIDAC has used up its burst.
  always_comb begin
    owner_d = OwnNone;
    burst_d = '0;
    if (vidac_req && (!cpu_req || (burst_q < BurstMax))) begin
      owner_d = OwnVidac;
      burst_d = (burst_q == BurstMax) ? burst_q : burst_q + BurstW'(1);
    end else if (cpu_req) begin
      owner_d = OwnCpu;
    end
  end

  // Memory port steering; a grant whose request already dropped is a dead cycle.
  always_comb begin
    cpu_gnt    = (owner_q == OwnCpu);
    vidac_gnt  = (owner_q == OwnVidac);
    cpu_act    = cpu_gnt & cpu_req;
    vidac_act  = vidac_gnt & vidac_req;
    // Truncation to 20 bits makes relocation wrap at the top of memory.
    vidac_phys = VIDAC_BASE + {2'b00, vidac_a};
    mem_a      = vidac_gnt ? vidac_phys : cpu_address;
    mem_d      = vidac_gnt ? vidac_o : cpu_out;
    mem_we     = (cpu_act & cpu_we) | (vidac_act & vidac_w);
  end

  // Read pipelines: rvalid marks the cycle after a live granted read; data is held afterwards.
  always_comb begin
    cpu_rvalid_d   = cpu_act & ~cpu_we;
    vidac_rvalid_d = vidac_act & ~vidac_w;
    cpu_hold_d     = cpu_rvalid_q ? mem_q : cpu_hold_q;
    vidac_hold_d   = vidac_rvalid_q ? mem_q : vidac_hold_q;
    cpu_rvalid     = cpu_rvalid_q;
    vidac_rvalid   = vidac_rvalid_q;
    cpu_in         = cpu_rvalid_q ? mem_q : cpu_hold_q;
    vidac_i        = vidac_rvalid_q ? mem_q : vidac_hold_q;
  end

  // Arbitration and read-pipeline state; reset clears the owner immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q        <= OwnNone;
      burst_q        <= '0;
      cpu_rvalid_q   <= 1'b0;
      vidac_rvalid_q <= 1'b0;
      cpu_hold_q     <= 8'h00;
      vidac_hold_q   <= 8'h00;
    end else begin
      owner_q        <= owner_d;
      burst_q        <= burst_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
      vidac_rvalid_q <= vidac_rvalid_d;
      cpu_hold_q     <= cpu_hold_d;
      vidac_hold_q   <= vidac_hold_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stat_q, stat_d;

  // Count cycles in which the CPU is asking but not owning the port; saturate at all-ones.
  always_comb begin
    stat_d = stat_q;
    if (cpu_req && !cpu_gnt && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_q <= 16'h0000;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cpu_stall = stat_q;
`else
  assign stat_cpu_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of the arbiter corner cases, then randomized CPU/VIDAC
// traffic against a reference byte memory with per-master expected-read queues.

module tb_mem_arbiter;

  localparam int unsigned B = 4;
  localparam logic [19:0] Base = 20'hA0000;
  localparam logic [19:0] WrapBase = 20'hF0000;

  typedef struct {
    logic [7:0]  d;
    int unsigned cyc;
  } exp_t;

  logic        clock, reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [19:0] cpu_address;
  logic [7:0]  cpu_out, cpu_in;
  logic        vidac_req, vidac_w, vidac_gnt, vidac_rvalid;
  logic [17:0] vidac_a;
  logic [7:0]  vidac_o, vidac_i;
  logic [19:0] mem_a;
  logic [7:0]  mem_d, mem_q;
  logic        mem_we;
  logic [15:0] stat_cpu_stall;

  logic        w_cpu_gnt, w_cpu_rvalid, w_vidac_gnt, w_vidac_rvalid, w_mem_we;
  logic [7:0]  w_cpu_in, w_vidac_i, w_mem_d;
  logic [19:0] w_mem_a;
  logic [15:0] w_stat;

  logic [7:0]  mem [0:1048575];
  logic [7:0]  ref_mem [int];
  exp_t        cpu_q[$];
  exp_t        vid_q[$];
  int unsigned cyc;
  int          n_chk, n_pass;
  bit          rand_en, mon_en;
  logic [7:0]  last_cpu, last_vid;
  int          stat_m;

  mem_arbiter #(.VIDAC_BASE(Base), .VIDAC_BURST(B)) u_dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_in(cpu_in),
    .vidac_req(vidac_req), .vidac_a(vidac_a), .vidac_o(vidac_o), .vidac_w(vidac_w),
    .vidac_gnt(vidac_gnt), .vidac_rvalid(vidac_rvalid), .vidac_i(vidac_i),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q),
    .stat_cpu_stall(stat_cpu_stall)
  );

  // Second instance only to observe address wrap with a high base.
  mem_arbiter #(.VIDAC_BASE(WrapBase), .VIDAC_BURST(B)) u_wrap (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_gnt(w_cpu_gnt), .cpu_rvalid(w_cpu_rvalid), .cpu_in(w_cpu_in),
    .vidac_req(vidac_req), .vidac_a(vidac_a), .vidac_o(vidac_o), .vidac_w(vidac_w),
    .vidac_gnt(w_vidac_gnt), .vidac_rvalid(w_vidac_rvalid), .vidac_i(w_vidac_i),
    .mem_a(w_mem_a), .mem_d(w_mem_d), .mem_we(w_mem_we), .mem_q(mem_q),
    .stat_cpu_stall(w_stat)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(logic [19:0] a);
    return (a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]}) | 8'h01;
  endfunction

  function automatic logic [19:0] vphys(logic [19:0] base, logic [17:0] a);
    logic [31:0] s;
    s = {12'h0, base} + {14'h0, a};
    return s[19:0];
  endfunction

  function automatic logic [7:0] ref_rd(logic [19:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, want, $time);
  endtask

  // Memory model: 1-cycle registered read, write on rising edge.
  initial begin : memory
    for (int i = 0; i < 1048576; i++) mem[i] = init_val(20'(i));
    mem[20'h00010] = 8'h03;
    mem[20'h00020] = 8'h5A;
    forever begin
      @(posedge clock);
      mem_q <= mem[mem_a];
      if (mem_we) mem[mem_a] = mem_d;
    end
  end

  function automatic logic [19:0] cpu_pick();
    logic [19:0] off;
    off = 20'($urandom_range(15));
    case ($urandom_range(2))
      0:       return 20'h00100 + off;
      1:       return 20'hA0100 + off;
      default: return 20'hDFFF0 + off;
    endcase
  endfunction

  function automatic logic [17:0] vid_pick();
    logic [17:0] off;
    off = 18'($urandom_range(15));
    if ($urandom_range(1) == 0) return 18'h00100 + off;
    return 18'h3FFF0 + off;
  endfunction

  // CPU master: one transaction at a time, held until granted.
  initial begin : cpu_drv
    int wt;
    bit done;
    done = 1'b1;
    wt = 0;
    wait (rand_en);
    while (rand_en || !done) begin
      @(posedge clock); #1;
      if (done) begin
        cpu_req = 1'b0;
        if (rand_en && ($urandom_range(3) != 0)) begin
          cpu_req = 1'b1;
          cpu_address = cpu_pick();
          cpu_we = 1'($urandom_range(1));
          cpu_out = 8'($urandom);
          wt = 0;
          done = 1'b0;
        end
      end
      @(negedge clock);
      if (!done) begin
        if (cpu_gnt) begin
          chk("cpu_wait_bound", 32'(wt <= int'(B) + 1), 1);
          chk("cpu_mem_a", 32'(mem_a), 32'(cpu_address));
          chk("cpu_mem_we", 32'(mem_we), 32'(cpu_we));
          if (cpu_we) begin
            chk("cpu_mem_d", 32'(mem_d), 32'(cpu_out));
            ref_mem[int'(cpu_address)] = cpu_out;
          end else begin
            cpu_q.push_back('{d: ref_rd(cpu_address), cyc: cyc + 1});
          end
          done = 1'b1;
        end else begin
          wt++;
          if (wt > int'(B) + 5) begin
            chk("cpu_starved", 32'(wt), 32'(B + 1));
            done = 1'b1;
          end
        end
      end
    end
    @(posedge clock); #1;
    cpu_req = 1'b0;
  end

  // VIDAC master: same protocol, relocated addresses.
  initial begin : vid_drv
    int wt;
    bit done;
    done = 1'b1;
    wt = 0;
    wait (rand_en);
    while (rand_en || !done) begin
      @(posedge clock); #1;
      if (done) begin
        vidac_req = 1'b0;
        if (rand_en && ($urandom_range(4) != 0)) begin
          vidac_req = 1'b1;
          vidac_a = vid_pick();
          vidac_w = 1'($urandom_range(1));
          vidac_o = 8'($urandom);
          wt = 0;
          done = 1'b0;
        end
      end
      @(negedge clock);
      if (!done) begin
        if (vidac_gnt) begin
          chk("vid_wait_bound", 32'(wt <= 1), 1);
          chk("vid_mem_a", 32'(mem_a), 32'(vphys(Base, vidac_a)));
          chk("vid_mem_we", 32'(mem_we), 32'(vidac_w));
          if (vidac_w) begin
            chk("vid_mem_d", 32'(mem_d), 32'(vidac_o));
            ref_mem[int'(vphys(Base, vidac_a))] = vidac_o;
          end else begin
            vid_q.push_back('{d: ref_rd(vphys(Base, vidac_a)), cyc: cyc + 1});
          end
          done = 1'b1;
        end else begin
          wt++;
          if (wt > 6) begin
            chk("vid_starved", 32'(wt), 1);
            done = 1'b1;
          end
        end
      end
    end
    @(posedge clock); #1;
    vidac_req = 1'b0;
  end

  // Monitor: pops expected read data exactly when rvalid is due; checks holds otherwise.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (mon_en) begin
        chk("gnt_exclusive", 32'(cpu_gnt & vidac_gnt), 0);
        if ((cpu_q.size() > 0) && (cpu_q[0].cyc == cyc)) begin
          e = cpu_q.pop_front();
          chk("cpu_rvalid", 32'(cpu_rvalid), 1);
          chk("cpu_rdata", 32'(cpu_in), 32'(e.d));
          last_cpu = e.d;
        end else begin
          chk("cpu_no_rvalid", 32'(cpu_rvalid), 0);
          chk("cpu_hold", 32'(cpu_in), 32'(last_cpu));
        end
        if ((vid_q.size() > 0) && (vid_q[0].cyc == cyc)) begin
          e = vid_q.pop_front();
          chk("vid_rvalid", 32'(vidac_rvalid), 1);
          chk("vid_rdata", 32'(vidac_i), 32'(e.d));
          last_vid = e.d;
        end else begin
          chk("vid_no_rvalid", 32'(vidac_rvalid), 0);
          chk("vid_hold", 32'(vidac_i), 32'(last_vid));
        end
`ifdef ARB_STATS_EN
        chk("stat_model", 32'(stat_cpu_stall), 32'(stat_m));
        if (cpu_req && !cpu_gnt && (stat_m < 65535)) stat_m++;
`else
        chk("stat_zero", 32'(stat_cpu_stall), 0);
`endif
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_address = '0; cpu_out = '0;
    vidac_req = 1'b0; vidac_w = 1'b0; vidac_a = '0; vidac_o = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin : main
    bit found;
    int exp_g;
    n_chk = 0; n_pass = 0;
    rand_en = 1'b0; mon_en = 1'b0;
    last_cpu = 8'h00; last_vid = 8'h00; stat_m = 0;
    do_reset();

    // Reset state.
    @(negedge clock);
    chk("rst_gnts", {30'b0, cpu_gnt, vidac_gnt}, 0);
    chk("rst_rvalids", {30'b0, cpu_rvalid, vidac_rvalid}, 0);
    chk("rst_rdata", {16'b0, cpu_in, vidac_i}, 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_stat", 32'(stat_cpu_stall), 0);

    // CPU read of 0x10, then a dead cycle carrying a write strobe that must not write.
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_address = 20'h00010; cpu_we = 1'b0;
    @(negedge clock);
    chk("t1_gnt_cycle1", 32'(cpu_gnt), 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t1_gnt_cycle2", 32'(cpu_gnt), 1);
    chk("t1_mem_a", 32'(mem_a), 32'h00010);
    chk("t1_mem_we", 32'(mem_we), 0);
    @(posedge clock); #1;
    cpu_req = 1'b0; cpu_address = 20'h00020; cpu_we = 1'b1; cpu_out = 8'hEE;
    @(negedge clock);
    chk("t1_rvalid", 32'(cpu_rvalid), 1);
    chk("t1_rdata", 32'(cpu_in), 32'h03);
    chk("t1_dead_we", 32'(mem_we), 0);
    @(posedge clock); #1;
    cpu_we = 1'b0;
    @(negedge clock);
    chk("t1_rvalid_off", 32'(cpu_rvalid), 0);
    chk("t1_held", 32'(cpu_in), 32'h03);
    chk("t1_dead_no_write", 32'(mem[20'h00020]), 32'h5A);

    // VIDAC write at offset 0 lands at the base.
    @(posedge clock); #1;
    vidac_req = 1'b1; vidac_w = 1'b1; vidac_a = 18'h00000; vidac_o = 8'hAA;
    @(negedge clock);
    chk("t2_gnt_cycle1", 32'(vidac_gnt), 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("t2_gnt", 32'(vidac_gnt), 1);
    chk("t2_mem_a", 32'(mem_a), 32'hA0000);
    chk("t2_mem_d", 32'(mem_d), 32'hAA);
    chk("t2_mem_we", 32'(mem_we), 1);
    @(posedge clock); #1;
    vidac_req = 1'b0; vidac_o = 8'h11;
    @(negedge clock);
    chk("t2_dead_we", 32'(mem_we), 0);
    chk("t2_written", 32'(mem[20'hA0000]), 32'hAA);
    chk("t2_no_rvalid", 32'(vidac_rvalid), 0);

    // Both masters reading from reset: grant pattern and stall count.
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_address = 20'h00400;
    vidac_req = 1'b1; vidac_w = 1'b0; vidac_a = 18'h00300;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clock);
      if (k == 0) exp_g = 0;
      else exp_g = (((k - 1) % (int'(B) + 1)) < int'(B)) ? 2 : 1;
      chk($sformatf("t3_grant_%0d", k), {30'b0, vidac_gnt, cpu_gnt}, 32'(exp_g));
    end
`ifdef ARB_STATS_EN
    chk("t6_stat", 32'(stat_cpu_stall), 9);
`else
    chk("t6_stat", 32'(stat_cpu_stall), 0);
`endif

    // Reset during a VIDAC write grant drops everything without a clock edge.
    @(posedge clock); #1;
    cpu_req = 1'b0; vidac_w = 1'b1; vidac_a = 18'h00200; vidac_o = 8'h55;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      @(negedge clock);
      if (vidac_gnt && mem_we) found = 1'b1;
    end
    chk("t5_write_grant", 32'(found), 1);
    #1 reset = 1'b1;
    #1;
    chk("t5_mem_we", 32'(mem_we), 0);
    chk("t5_gnts", {30'b0, cpu_gnt, vidac_gnt}, 0);
    chk("t5_rvalids", {30'b0, cpu_rvalid, vidac_rvalid}, 0);
    chk("t5_rdata", {16'b0, cpu_in, vidac_i}, 0);
    vidac_req = 1'b0; vidac_w = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t5_no_write", 32'(mem[20'hA0200]), 32'(init_val(20'hA0200)));

    // Relocation at the top of VIDAC space, with and without wrap.
    @(posedge clock); #1;
    vidac_req = 1'b1; vidac_a = 18'h3FFFF;
    found = 1'b0;
    for (int k = 0; k < 3 && !found; k++) begin
      @(negedge clock);
      if (vidac_gnt) begin
        found = 1'b1;
        chk("t4_mem_a", 32'(mem_a), 32'(vphys(Base, 18'h3FFFF)));
        chk("t4_wrap_gnt", 32'(w_vidac_gnt), 1);
        chk("t4_wrap_mem_a", 32'(w_mem_a), 32'h2FFFF);
      end
    end
    chk("t4_granted", 32'(found), 1);
    @(posedge clock); #1;
    vidac_req = 1'b0;
    repeat (3) @(negedge clock);

    // Randomized traffic.
    do_reset();
    last_cpu = 8'h00; last_vid = 8'h00; stat_m = 0;
    mon_en = 1'b1;
    rand_en = 1'b1;
    repeat (3000) @(posedge clock);
    rand_en = 1'b0;
    repeat (12) @(negedge clock);
    mon_en = 1'b0;
    chk("cpu_q_drained", 32'(cpu_q.size()), 0);
    chk("vid_q_drained", 32'(vid_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
